// File: rtl/image_bus_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : image_bus_master_pkg
//  Purpose  : Shared definitions for the process-image bus master: FSM state
//             encoding, LEN decode (code 0 = full block) and the address /
//             block-size defaults shared with the semaphore bit memory and
//             the bit CPU.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package image_bus_master_pkg;

    // Defaults shared with the semaphore memory and bit CPU
    localparam int C_AW_DEFAULT = 12;
    localparam int C_NB_DEFAULT = 16;

    // LEN code that selects a full NB-bit block
    localparam int C_LEN_FULL_CODE = 0;

    // FSM encoding (VREQ/VCAP only reachable with the verify pass built in)
    localparam int C_STATE_W = 3;
    typedef logic [C_STATE_W-1:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_WREQ = 3'd1;
    localparam state_t S_RREQ = 3'd2;
    localparam state_t S_RCAP = 3'd3;
    localparam state_t S_FIN  = 3'd4;
    localparam state_t S_VREQ = 3'd5;
    localparam state_t S_VCAP = 3'd6;

    // Bit count of a block: code 0 (and anything beyond NB) means NB bits
    function automatic int decode_len(input int len, input int nb);
        if (len == C_LEN_FULL_CODE || len > nb) begin
            return nb;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_bus_master_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : img_bus_addr_gen
//  Purpose  : Bit index counter and address generator shared by the write,
//             read and verify phases. Address = base + idx, wrapping modulo
//             2^AW.
//  Ports    : clk, rst      - clock / synchronous active-high reset
//             clear         - force idx to 0 (priority over advance)
//             advance       - step idx by one
//             base          - first bit address of the block
//             last_idx      - index of the final bit of the block
//             idx, addr     - current bit index and bit address
//             is_last       - current idx is the final bit
//  Revision : 1.0 - initial release
// ============================================================================
module img_bus_addr_gen #(
    parameter int AW = 12,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [AW-1:0] base,
    input  logic [IW-1:0] last_idx,
    output logic [IW-1:0] idx,
    output logic [AW-1:0] addr,
    output logic          is_last
);

    logic [IW-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (clear) begin
            r_idx <= '0;
        end else if (advance) begin
            r_idx <= r_idx + IW'(1);
        end
    end

    // Natural AW-bit overflow gives the modulo-2^AW wrap
    assign addr    = base + AW'(r_idx);
    assign idx     = r_idx;
    assign is_last = (r_idx == last_idx);

endmodule
`default_nettype wire

// File: rtl/image_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : image_bus_master
//  Purpose  : Copies a block of 1..NB process-image bits between a bit-address
//             window of the shared semaphore bit memory and a parallel
//             register pair, driving the bit-CPU style A/DO/WE/OE lines and
//             stalling on M_RDY.
//  Ports    : CLK/CLR           - clock / synchronous active-high reset
//             START/DIR/BASE/LEN/PAR_IN - block request (latched on START)
//             PAR_OUT           - read result register
//             BUSY/DONE/ERR     - status (ERR = verify mismatch, sticky)
//             M_A/M_DO/M_WE/M_OE/M_DI/M_RDY - memory port
//  Config   : IMG_BUS_VERIFY_EN - adds a read-back verify pass after every
//             write block; without it ERR is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module image_bus_master
    import image_bus_master_pkg::*;
#(
    parameter int AW = C_AW_DEFAULT,
    parameter int NB = C_NB_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 START,
    input  logic                 DIR,
    input  logic [AW-1:0]        BASE,
    input  logic [$clog2(NB):0]  LEN,
    input  logic [NB-1:0]        PAR_IN,
    output logic [NB-1:0]        PAR_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [AW-1:0]        M_A,
    output logic                 M_DO,
    output logic                 M_WE,
    output logic                 M_OE,
    input  logic                 M_DI,
    input  logic                 M_RDY
);

    localparam int IW = $clog2(NB);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_base;
    logic [NB-1:0] r_par_in;
    logic [NB-1:0] r_mask;
    logic [NB-1:0] r_shadow;
    logic [NB-1:0] r_par_out;
    logic [IW-1:0] r_last;

    int            w_len_cnt;
    logic [IW-1:0] w_last;
    logic [NB-1:0] w_mask;
    logic [NB-1:0] w_shadow_nxt;
    logic [IW-1:0] w_idx;
    logic [AW-1:0] w_addr;
    logic          w_is_last;
    logic          w_clear;
    logic          w_advance;
    logic          w_start_ok;

    assign w_start_ok = (r_state == S_IDLE) && START;

    // ---------------------------------------------------------------- LEN
    always_comb begin
        w_len_cnt = decode_len(int'(LEN), NB);
        w_last    = IW'(w_len_cnt - 1);
        for (int i = 0; i < NB; i++) begin
            w_mask[i] = (i < w_len_cnt);
        end
    end

    // ------------------------------------------------------ address / idx
    // idx is parked at 0 while idle and rewound when the write phase hands
    // over to the verify pass.
    assign w_clear   = (r_state == S_IDLE) ||
                       ((r_state == S_WREQ) && M_RDY && w_is_last);
    assign w_advance = ((r_state == S_WREQ) && M_RDY) ||
                       (r_state == S_RCAP) || (r_state == S_VCAP);

    img_bus_addr_gen #(
        .AW (AW),
        .IW (IW)
    ) u_addr_gen (
        .clk      (CLK),
        .rst      (CLR),
        .clear    (w_clear),
        .advance  (w_advance),
        .base     (r_base),
        .last_idx (r_last),
        .idx      (w_idx),
        .addr     (w_addr),
        .is_last  (w_is_last)
    );

    // ----------------------------------------------------- state register
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = DIR ? S_WREQ : S_RREQ;
                end
            end
            S_WREQ: begin
                if (M_RDY && w_is_last) begin
`ifdef IMG_BUS_VERIFY_EN
                    w_state_nxt = S_VREQ;
`else
                    w_state_nxt = S_FIN;
`endif
                end
            end
            S_RREQ: begin
                if (M_RDY) begin
                    w_state_nxt = S_RCAP;
                end
            end
            S_RCAP: begin
                w_state_nxt = w_is_last ? S_FIN : S_RREQ;
            end
`ifdef IMG_BUS_VERIFY_EN
            S_VREQ: begin
                if (M_RDY) begin
                    w_state_nxt = S_VCAP;
                end
            end
            S_VCAP: begin
                w_state_nxt = w_is_last ? S_FIN : S_VREQ;
            end
`endif
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------- output decode
    always_comb begin
        M_WE = 1'b0;
        M_OE = 1'b0;
        M_DO = 1'b0;
        DONE = 1'b0;
        BUSY = (r_state != S_IDLE);
        M_A  = w_addr;
        case (r_state)
            S_WREQ: begin
                M_WE = 1'b1;
                M_DO = r_par_in[w_idx];
            end
            S_RREQ, S_VREQ: M_OE = 1'b1;
            S_FIN:          DONE = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_comb begin
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[w_idx] = M_DI;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_base    <= '0;
            r_par_in  <= '0;
            r_mask    <= '0;
            r_last    <= '0;
            r_shadow  <= '0;
            r_par_out <= '0;
        end else begin
            if (w_start_ok) begin
                r_base   <= BASE;
                r_par_in <= PAR_IN;
                r_mask   <= w_mask;
                r_last   <= w_last;
            end
            if (r_state == S_RCAP) begin
                r_shadow <= w_shadow_nxt;
                // Final capture merges straight into PAR_OUT so the result
                // is visible while DONE is high; bits past LEN are kept.
                if (w_is_last) begin
                    r_par_out <= (r_par_out & ~r_mask) | (w_shadow_nxt & r_mask);
                end
            end
        end
    end

    assign PAR_OUT = r_par_out;

`ifdef IMG_BUS_VERIFY_EN
    logic r_err;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if ((r_state == S_VCAP) && (M_DI != r_par_in[w_idx])) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_image_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_image_bus_master
//  Purpose  : Scoreboard bench for image_bus_master. Stimulus tasks push the
//             expected write strobes, read strobes and DONE results; a
//             monitor/memory-model process pops and compares them as the DUT
//             presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_image_bus_master;

    localparam int AW = 12;
    localparam int NB = 16;
`ifdef IMG_BUS_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          CLK    = 1'b0;
    logic          CLR    = 1'b1;
    logic          START  = 1'b0;
    logic          DIR    = 1'b0;
    logic [AW-1:0] BASE   = '0;
    logic [4:0]    LEN    = '0;
    logic [NB-1:0] PAR_IN = '0;
    logic [NB-1:0] PAR_OUT;
    logic          BUSY, DONE, ERR;
    logic [AW-1:0] M_A;
    logic          M_DO, M_WE, M_OE;
    logic          M_DI   = 1'b0;
    logic          M_RDY  = 1'b1;

    image_bus_master #(.AW(AW), .NB(NB)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .DIR(DIR), .BASE(BASE),
        .LEN(LEN), .PAR_IN(PAR_IN), .PAR_OUT(PAR_OUT), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .M_A(M_A), .M_DO(M_DO), .M_WE(M_WE),
        .M_OE(M_OE), .M_DI(M_DI), .M_RDY(M_RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [AW-1:0] a; logic d; } wr_t;
    typedef struct { int cyc; logic [NB-1:0] par; logic err; } done_t;

    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    done_t         done_q[$];

    int            checks   = 0;
    int            errors   = 0;
    int            cyc      = 0;
    int            done_cnt = 0;
    int            done_exp = 0;
    logic          mem [0:(1<<AW)-1];
    logic [NB-1:0] model_par = '0;

    logic          stall_arm    = 1'b0;
    logic [AW-1:0] stall_addr   = '0;
    int            stall_left   = 0;
    logic          corrupt_en   = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------- memory model + monitor
    initial begin : monitor
        wr_t           we;
        done_t         de;
        logic [AW-1:0] ra;
        logic          rd_pend = 1'b0;
        logic [AW-1:0] rd_addr = '0;
        logic          prev_stalled = 1'b0;
        logic [AW-1:0] prev_a = '0;
        logic          prev_do = 1'b0, prev_we = 1'b0, prev_oe = 1'b0;
        forever begin
            @(negedge CLK);
            if (stall_arm && M_WE && M_A == stall_addr) begin
                stall_arm  = 1'b0;
                M_RDY      = 1'b0;
                stall_left = 2;
            end
            if (prev_stalled) begin
                check("stall_addr_stable", 32'(M_A), 32'(prev_a));
                check("stall_do_stable",   32'(M_DO), 32'(prev_do));
                check("stall_we_stable",   32'(M_WE), 32'(prev_we));
                check("stall_oe_stable",   32'(M_OE), 32'(prev_oe));
            end
            prev_stalled = (M_WE || M_OE) && !M_RDY;
            prev_a = M_A; prev_do = M_DO; prev_we = M_WE; prev_oe = M_OE;
            if (M_WE || M_OE) check("we_oe_exclusive", 32'(M_WE & M_OE), 32'd0);
            if (M_WE && M_RDY) begin
                mem[M_A] = M_DO;
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data %0b, none required", M_A, M_DO);
                end else begin
                    we = wr_q.pop_front();
                    check("write_addr", 32'(M_A), 32'(we.a));
                    check("write_data", 32'(M_DO), 32'(we.d));
                end
            end
            if (M_OE && M_RDY) begin
                rd_pend = 1'b1;
                rd_addr = M_A;
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr 0x%0h, none required", M_A);
                end else begin
                    ra = rd_q.pop_front();
                    check("read_addr", 32'(M_A), 32'(ra));
                end
            end
            if (DONE) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: DONE=1 at cycle %0d, none required", cyc);
                end else begin
                    de = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(de.cyc));
                    check("done_par_out", 32'(PAR_OUT), 32'(de.par));
                    check("done_err", 32'(ERR), 32'(de.err));
                end
            end
            @(posedge CLK);
            cyc++;
            #1;
            if (stall_left > 0) begin
                stall_left--;
                M_RDY = 1'b0;
            end else begin
                M_RDY = 1'b1;
            end
            if (rd_pend) begin
                M_DI    = mem[rd_addr] ^ (corrupt_en && rd_addr == corrupt_addr);
                rd_pend = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic issue_write(input logic [AW-1:0] base, input int len,
                               input logic [NB-1:0] data, input int stalls,
                               input logic exp_err);
        int    n = (len == 0) ? NB : len;
        wr_t   e;
        done_t d;
        @(posedge CLK); #1;
        for (int i = 0; i < n; i++) begin
            e.a = base + AW'(i);
            e.d = data[i];
            wr_q.push_back(e);
            if (VERIFY) rd_q.push_back(base + AW'(i));
        end
        d.cyc = cyc + 1 + n + stalls + (VERIFY ? 2 * n : 0);
        d.par = model_par;
        d.err = VERIFY ? exp_err : 1'b0;
        done_q.push_back(d);
        done_exp++;
        START = 1'b1; DIR = 1'b1; BASE = base; LEN = 5'(len); PAR_IN = data;
        @(posedge CLK); #1;
        START = 1'b0; DIR = 1'b0; BASE = '0; LEN = '0; PAR_IN = '0;
    endtask

    task automatic issue_read(input logic [AW-1:0] base, input int len, input bit want_done);
        int    n = (len == 0) ? NB : len;
        done_t d;
        @(posedge CLK); #1;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(base + AW'(i));
            if (want_done) model_par[i] = mem[base + AW'(i)];
        end
        if (want_done) begin
            d.cyc = cyc + 1 + 2 * n;
            d.par = model_par;
            d.err = 1'b0;
            done_q.push_back(d);
            done_exp++;
        end
        START = 1'b1; DIR = 1'b0; BASE = base; LEN = 5'(len);
        @(posedge CLK); #1;
        START = 1'b0; BASE = '0; LEN = '0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt < done_exp && k < 400) begin
            @(posedge CLK);
            k++;
        end
        check("done_seen", 32'(done_cnt), 32'(done_exp));
    endtask

    task automatic preload(input logic [AW-1:0] base, input int n, input logic [NB-1:0] pat);
        for (int i = 0; i < n; i++) mem[base + AW'(i)] = pat[i];
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < (1 << AW); i++) mem[i] = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_par_out", 32'(PAR_OUT), 32'h0);
        check("rst_busy",    32'(BUSY), 32'h0);
        check("rst_done",    32'(DONE), 32'h0);
        check("rst_err",     32'(ERR), 32'h0);
        check("rst_m_a",     32'(M_A), 32'h0);
        check("rst_m_do",    32'(M_DO), 32'h0);
        check("rst_m_we",    32'(M_WE), 32'h0);
        check("rst_m_oe",    32'(M_OE), 32'h0);
        CLR = 1'b0;

        // Full 16-bit write, no stalls
        issue_write(12'h010, 16, 16'hF0F0, 0, 1'b0);
        wait_done();

        // LEN=0 read of a preloaded pattern (16 bits)
        preload(12'h200, 16, 16'h5A3C);
        issue_read(12'h200, 0, 1'b1);
        wait_done();

        // 4-bit read: memory 1,0,1,1 -> low nibble 0xD, upper bits kept
        preload(12'h020, 4, 16'h000D);
        issue_read(12'h020, 4, 1'b1);
        wait_done();

        // Three-cycle M_RDY stall on bit 2 of a write
        stall_addr = 12'h042;
        stall_arm  = 1'b1;
        issue_write(12'h040, 8, 16'h003C, 3, 1'b0);
        wait_done();

        // Address wrap, plus a START poke while busy
        issue_write(12'hFFF, 2, 16'h0001, 0, 1'b0);
        check("busy_in_block", 32'(BUSY), 32'h1);
        START = 1'b1; DIR = 1'b0; BASE = 12'h300; LEN = 5'd3;
        @(posedge CLK); #1;
        START = 1'b0; BASE = '0; LEN = '0;
        wait_done();

        // Verify pass: bit 5 corrupted on read-back, then a clean rerun
        corrupt_addr = 12'h105;
        corrupt_en   = 1'b1;
        issue_write(12'h100, 8, 16'h00A5, 0, 1'b1);
        wait_done();
        corrupt_en = 1'b0;
        issue_write(12'h100, 8, 16'h00A5, 0, 1'b0);
        wait_done();

        // Abort a read mid-block
        issue_read(12'h200, 8, 1'b0);
        repeat (4) @(posedge CLK);
        #1 CLR = 1'b1;
        @(posedge CLK);
        #2;
        check("abort_par_out", 32'(PAR_OUT), 32'h0);
        check("abort_busy",    32'(BUSY), 32'h0);
        check("abort_done",    32'(DONE), 32'h0);
        check("abort_err",     32'(ERR), 32'h0);
        check("abort_m_a",     32'(M_A), 32'h0);
        check("abort_m_we",    32'(M_WE), 32'h0);
        check("abort_m_oe",    32'(M_OE), 32'h0);
        check("abort_m_do",    32'(M_DO), 32'h0);
        CLR = 1'b0;
        model_par = '0;
        rd_q.delete();
        repeat (30) @(posedge CLK);

        // Recovery after abort
        issue_read(12'h020, 4, 1'b1);
        wait_done();

        repeat (3) @(posedge CLK);
        check("wr_q_drained",   32'(wr_q.size()), 32'd0);
        check("rd_q_drained",   32'(rd_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_bus_master.md
# image_bus_master

Bus initiator for one port of the three-port semaphore bit memory: it copies a block of up to 16 process-image bits between a 12-bit bit-address window in shared memory and a parallel 16-bit register pair. It drives the same A/DO/WE/OE lines a bit CPU drives, and stalls on the port's wait/ready line. System control or a word CPU uses it to load or store whole process-image words without per-bit software.

## Interface
Parameters:
- AW, 12, bit-memory address width
- NB, 16, maximum bits per block; LEN width is clog2(NB)+1

Ports:
- CLK  in  1  system clock, rising edge
- CLR  in  1  reset, synchronous, active-high
- START  in  1  one-cycle request; sampled only in IDLE
- DIR  in  1  0 = read memory into PAR_OUT, 1 = write PAR_IN into memory; latched at START
- BASE  in  AW  first bit address; latched at START
- LEN  in  5  bit count, 1..16; 0 means 16; latched at START
- PAR_IN  in  NB  write data; latched at START
- PAR_OUT  out  NB  read result register
- BUSY  out  1  high from the cycle after START acceptance until DONE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  verify mismatch flag (only with verify compiled in, otherwise tied 0)
- M_A  out  AW  memory bit address
- M_DO  out  1  write data bit
- M_WE  out  1  write strobe
- M_OE  out  1  read strobe
- M_DI  in  1  read data; valid the cycle after read acceptance
- M_RDY  in  1  port ready; a strobe is accepted at a rising edge where the strobe and M_RDY are both 1

## Operation
- FSM states: IDLE, WREQ, RREQ, RCAP, FIN. With verify compiled in, VREQ and VCAP are added.
- IDLE: on START, latch DIR/BASE/LEN/PAR_IN, clear idx, clear ERR, then go to WREQ (DIR=1) or RREQ (DIR=0).
- WREQ: M_WE=1, M_A=BASE+idx, M_DO=PAR_IN[idx]. Hold until accepted. On acceptance, idx+1; after the last bit go to FIN (or to VREQ with verify, idx cleared).
- RREQ: M_OE=1, M_A=BASE+idx. Hold until accepted, then go to RCAP.
- RCAP: no strobe; shadow[idx] <= M_DI; idx+1; go back to RREQ, or to FIN after the last bit.
- FIN: DONE=1. On a read, PAR_OUT bits 0..LEN-1 are loaded from the shadow register in this cycle; bits >= LEN keep their value. Go to IDLE.
- Address arithmetic is modulo 2^AW: BASE=0xFFF with LEN=2 touches 0xFFF then 0x000.
- M_WE and M_OE are never high together. Strobes are held stable while M_RDY=0.
- START while BUSY is ignored.
- CLR mid-block aborts the transfer immediately; no DONE is produced; memory already written stays written.

## Timing
- Reset values: PAR_OUT=0, BUSY=0, DONE=0, ERR=0, M_A=0, M_DO=0, M_WE=0, M_OE=0, state IDLE.
- All outputs are registered, decoded from state and registers with no combinational path from M_RDY.
- START at edge t gives the first strobe at edge t+1.
- Write bit: 1 cycle when M_RDY=1. Read bit: 2 cycles (request, capture).
- With M_RDY always 1, DONE is high in cycle t+1+LEN (write) or t+1+2·LEN (read).
- Each M_RDY=0 cycle adds one cycle.
- DONE is followed by IDLE; START is accepted again in the cycle after DONE.

## Configuration
- IMG_BUS_VERIFY_EN defined:
  - After a write block, every bit is re-read with the VREQ/VCAP sequence, using the same timing as RREQ/RCAP.
  - Any bit where M_DI ≠ PAR_IN[idx] sets ERR. ERR is sticky until the next accepted START.
  - DONE is delayed by the verify pass. PAR_OUT is unchanged by verify.
- IMG_BUS_VERIFY_EN undefined: the VREQ/VCAP states are absent and ERR is constant 0.

## Structure
- Shared package holds: the FSM state encoding, the LEN=0→NB decode constant, and the AW/NB defaults shared with the semaphore memory and bit CPU.
- One sub-module, img_bus_addr_gen: the idx counter, the last-bit compare and BASE+idx modulo 2^AW. It is reused by the write, read and verify phases.

## Test plan
- Write, LEN=16, BASE=0x010, PAR_IN=0xF0F0, M_RDY=1 → 16 WE strobes at 0x010..0x01F with M_DO matching the bits; DONE at t+17.
- Read, LEN=4, BASE=0x020 with memory=1,0,1,1 → PAR_OUT[3:0]=0xD (bit0=1), upper bits unchanged, DONE at t+9.
- M_RDY low for 3 cycles on bit 2 of a write → strobe, address and data held stable; DONE 3 cycles later; no duplicate write.
- BASE=0xFFF, LEN=2 → addresses 0xFFF then 0x000. Also: START while BUSY → ignored.
- CLR asserted mid-read → all outputs at reset values the next cycle, no DONE, PAR_OUT=0.
- With IMG_BUS_VERIFY_EN, memory model corrupts bit 5 → ERR=1 at DONE; a clean rerun → ERR=0.
